// File: rtl/ctrl_pkg.sv
// ctrl_pkg
// Encodings shared by multi_cycle_ctrl, ctrl_decode and the datapath muxes:
// RV32I opcodes, sequencer states, instruction classes, select encodings
// and the decoded-instruction record latched in DECODE.
package ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IALU = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] WB_MEM = 2'b00;
  localparam logic [1:0] WB_ALU = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CL_R,
    CL_IALU,
    CL_LW,
    CL_SW,
    CL_BR,
    CL_JAL,
    CL_JALR,
    CL_ILL
  } iclass_t;

  typedef struct packed {
    iclass_t    cls;
    logic [2:0] funct3;
    logic       a_sel;
    logic       b_sel;
    logic [1:0] imm_sel;
    logic [3:0] alu_sel;
    logic [1:0] wb_sel;
  } dec_t;

  // BEQ takes on equal, BNE on not-equal; other funct3 values never reach here legally.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic breq);
    return ((funct3 == 3'b000) && breq) || ((funct3 == 3'b001) && !breq);
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode
// Combinational instruction classifier: opcode/funct3/funct7[5] to class
// plus the operand, immediate, ALU and write-back selects used in EXEC/MEM/WB.
// Ports:
//   opcode   in  7  inst[6:0]
//   funct3   in  3  inst[14:12]
//   funct7_5 in  1  inst[30]
//   dec      out    decoded record (class, funct3, selects)
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output dec_t       dec
);

  always_comb begin
    dec        = '0;
    dec.cls    = CL_ILL;
    dec.funct3 = funct3;
    case (opcode)
      OP_R: begin
        dec.cls     = CL_R;
        dec.alu_sel = {funct7_5, funct3};
        dec.wb_sel  = WB_ALU;
      end
      OP_IALU: begin
        dec.cls     = CL_IALU;
        dec.b_sel   = 1'b1;
        dec.imm_sel = IMM_I;
        dec.alu_sel = {1'b0, funct3};
        dec.wb_sel  = WB_ALU;
      end
      OP_LW: begin
        dec.cls     = CL_LW;
        dec.b_sel   = 1'b1;
        dec.imm_sel = IMM_I;
        dec.alu_sel = ALU_ADD;
        dec.wb_sel  = WB_MEM;
      end
      OP_SW: begin
        dec.cls     = CL_SW;
        dec.b_sel   = 1'b1;
        dec.imm_sel = IMM_S;
        dec.alu_sel = ALU_ADD;
      end
      OP_BR: begin
        dec.cls     = CL_BR;
        dec.a_sel   = 1'b1;
        dec.b_sel   = 1'b1;
        dec.imm_sel = IMM_B;
        dec.alu_sel = ALU_ADD;
      end
      OP_JAL: begin
        dec.cls     = CL_JAL;
        dec.a_sel   = 1'b1;
        dec.b_sel   = 1'b1;
        dec.imm_sel = IMM_J;
        dec.alu_sel = ALU_ADD;
        dec.wb_sel  = WB_PC4;
      end
      OP_JALR: begin
        dec.cls     = CL_JALR;
        dec.b_sel   = 1'b1;
        dec.imm_sel = IMM_I;
        dec.alu_sel = ALU_ADD;
        dec.wb_sel  = WB_PC4;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl
// Multi-cycle sequencer for the RV32I-subset datapath. Walks each instruction
// through FETCH/DECODE/EXEC/MEM/WB, holding on the memory req/ack handshakes,
// and counts retired instructions (one per PC write).
// Ports:
//   clk, rst_n          clock, async active-low reset
//   inst_i              instruction register contents (valid from DECODE)
//   breq_i              branch comparator equal flag
//   imem_ack_i/_req_o   instruction memory handshake
//   dmem_ack_i/_req_o   data memory handshake, dmem_we_o = store
//   ir_we_o, pc_we_o, rf_we_o   datapath write strobes
//   pc_sel_o, alu_sel_o, imm_sel_o, a_sel_o, b_sel_o, wb_sel_o   datapath selects
//   trap_o              sticky illegal-instruction / ack-timeout flag
//   instret_o           retired-instruction count
//
// state  | meaning
// IDLE   | one cycle after reset release
// FETCH  | imem request outstanding, IR loads on ack
// DECODE | classify inst_i, latch class and selects
// EXEC   | drive ALU selects; branches resolve and write PC here
// MEM    | dmem request outstanding, EXEC selects held for a stable address
// WB     | register file and PC write
// TRAP   | everything quiet until reset
module multi_cycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_i,
  input  logic             breq_i,
  input  logic             imem_ack_i,
  input  logic             dmem_ack_i,
  output logic             imem_req_o,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic             pc_sel_o,
  output logic             rf_we_o,
  output logic [3:0]       alu_sel_o,
  output logic [1:0]       imm_sel_o,
  output logic             a_sel_o,
  output logic             b_sel_o,
  output logic [1:0]       wb_sel_o,
  output logic             trap_o,
  output logic [CNT_W-1:0] instret_o
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LOAD = TW'(ACK_TIMEOUT);

  state_t        state;
  dec_t          dec_d;
  dec_t          dec_q;
  logic [TW-1:0] wait_cnt;
  logic          tmo_hit;
  logic          br_ok;
  logic          pc_we;
  logic          unused_inst_bits;

  assign unused_inst_bits = ^{inst_i[31], inst_i[29:15], inst_i[11:7]};

  ctrl_decode u_decode (
    .opcode   (inst_i[6:0]),
    .funct3   (inst_i[14:12]),
    .funct7_5 (inst_i[30]),
    .dec      (dec_d)
  );

  // Down-counter reloaded whenever a wait state is (re)entered; terminal
  // count 1 means ACK_TIMEOUT request cycles have gone by without an ack.
  assign tmo_hit = (ACK_TIMEOUT != 0) && (wait_cnt == TW'(1));
  assign br_ok   = (dec_q.funct3[2:1] == 2'b00);
  assign trap_o  = (state == ST_TRAP);
  assign pc_we_o = pc_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      dec_q     <= '0;
      wait_cnt  <= '0;
      instret_o <= '0;
    end else begin
      if (pc_we) instret_o <= instret_o + CNT_W'(1);
      case (state)
        ST_IDLE: begin
          wait_cnt <= TMO_LOAD;
          state    <= ST_FETCH;
        end
        ST_FETCH: begin
          if (imem_ack_i) begin
            wait_cnt <= TMO_LOAD;
            state    <= ST_DECODE;
          end else if (tmo_hit) begin
            state <= ST_TRAP;
          end else begin
            wait_cnt <= wait_cnt - TW'(1);
          end
        end
        ST_DECODE: begin
          wait_cnt <= TMO_LOAD;
          dec_q    <= dec_d;
          state    <= (dec_d.cls == CL_ILL) ? ST_TRAP : ST_EXEC;
        end
        ST_EXEC: begin
          wait_cnt <= TMO_LOAD;
          case (dec_q.cls)
            CL_BR:        state <= br_ok ? ST_FETCH : ST_TRAP;
            CL_LW, CL_SW: state <= ST_MEM;
            default:      state <= ST_WB;
          endcase
        end
        ST_MEM: begin
          if (dmem_ack_i) begin
            wait_cnt <= TMO_LOAD;
            state    <= (dec_q.cls == CL_SW) ? ST_FETCH : ST_WB;
          end else if (tmo_hit) begin
            state <= ST_TRAP;
          end else begin
            wait_cnt <= wait_cnt - TW'(1);
          end
        end
        ST_WB: begin
          wait_cnt <= TMO_LOAD;
          state    <= ST_FETCH;
        end
        default: state <= ST_TRAP;
      endcase
    end
  end

  // Strobes are decoded from the registered state plus the same-cycle
  // handshake/compare inputs, so an ack can be consumed in its own cycle.
  always_comb begin
    imem_req_o = 1'b0;
    ir_we_o    = 1'b0;
    dmem_req_o = 1'b0;
    dmem_we_o  = 1'b0;
    rf_we_o    = 1'b0;
    pc_we      = 1'b0;
    pc_sel_o   = 1'b0;
    alu_sel_o  = ALU_ADD;
    imm_sel_o  = IMM_I;
    a_sel_o    = 1'b0;
    b_sel_o    = 1'b0;
    wb_sel_o   = WB_MEM;
    case (state)
      ST_EXEC, ST_MEM, ST_WB: begin
        // held past EXEC so the ALU result (address / link target) stays put
        alu_sel_o = dec_q.alu_sel;
        imm_sel_o = dec_q.imm_sel;
        a_sel_o   = dec_q.a_sel;
        b_sel_o   = dec_q.b_sel;
      end
      default: ;
    endcase
    case (state)
      ST_FETCH: begin
        imem_req_o = 1'b1;
        ir_we_o    = imem_ack_i;
      end
      ST_EXEC: begin
        if ((dec_q.cls == CL_BR) && br_ok) begin
          pc_we    = 1'b1;
          pc_sel_o = branch_taken(dec_q.funct3, breq_i);
        end
      end
      ST_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = (dec_q.cls == CL_SW);
        pc_we      = dmem_ack_i && (dec_q.cls == CL_SW);
      end
      ST_WB: begin
        rf_we_o  = 1'b1;
        pc_we    = 1'b1;
        wb_sel_o = dec_q.wb_sel;
        pc_sel_o = (dec_q.cls == CL_JAL) || (dec_q.cls == CL_JALR);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl
// Drives instructions through the sequencer with random ack delays and
// spurious acks, predicting every cycle's strobes from the instruction's
// class and the handshake timing. A second instance checks the ack timeout.
module tb_multi_cycle_ctrl;

  localparam int C_R = 0, C_I = 1, C_LW = 2, C_SW = 3, C_BR = 4, C_JAL = 5, C_JALR = 6, C_ILL = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rst_t_n = 1'b1;
  logic [31:0] inst_i = '0;
  logic        breq_i = 1'b0;
  logic        imem_ack_i = 1'b0;
  logic        dmem_ack_i = 1'b0;

  logic        imem_req_o, dmem_req_o, dmem_we_o, ir_we_o, pc_we_o, pc_sel_o, rf_we_o;
  logic [3:0]  alu_sel_o;
  logic [1:0]  imm_sel_o;
  logic        a_sel_o, b_sel_o;
  logic [1:0]  wb_sel_o;
  logic        trap_o;
  logic [31:0] instret_o;

  wire  [7:0]  t_strobes;
  wire  [9:0]  t_unused_sels;
  wire  [31:0] t_instret;

  logic [7:0]  strobes;
  logic [7:0]  sels;
  assign strobes = {imem_req_o, ir_we_o, dmem_req_o, dmem_we_o, rf_we_o, pc_we_o, pc_sel_o, trap_o};
  assign sels    = {a_sel_o, b_sel_o, imm_sel_o, alu_sel_o};

  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] model_ret = '0;

  multi_cycle_ctrl #(.CNT_W(32), .ACK_TIMEOUT(0)) dut (
    .clk(clk), .rst_n(rst_n), .inst_i(inst_i), .breq_i(breq_i),
    .imem_ack_i(imem_ack_i), .dmem_ack_i(dmem_ack_i),
    .imem_req_o(imem_req_o), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o), .rf_we_o(rf_we_o),
    .alu_sel_o(alu_sel_o), .imm_sel_o(imm_sel_o), .a_sel_o(a_sel_o), .b_sel_o(b_sel_o),
    .wb_sel_o(wb_sel_o), .trap_o(trap_o), .instret_o(instret_o)
  );

  multi_cycle_ctrl #(.CNT_W(32), .ACK_TIMEOUT(4)) dut_tmo (
    .clk(clk), .rst_n(rst_t_n), .inst_i(32'h0), .breq_i(1'b0),
    .imem_ack_i(1'b0), .dmem_ack_i(1'b0),
    .imem_req_o(t_strobes[7]), .dmem_req_o(t_strobes[5]), .dmem_we_o(t_strobes[4]),
    .ir_we_o(t_strobes[6]), .pc_we_o(t_strobes[2]), .pc_sel_o(t_strobes[1]), .rf_we_o(t_strobes[3]),
    .alu_sel_o(t_unused_sels[3:0]), .imm_sel_o(t_unused_sels[5:4]), .a_sel_o(t_unused_sels[6]),
    .b_sel_o(t_unused_sels[7]), .wb_sel_o(t_unused_sels[9:8]), .trap_o(t_strobes[0]),
    .instret_o(t_instret)
  );

  initial forever #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int class_of(input logic [31:0] w);
    case (w[6:0])
      7'b0110011: return C_R;
      7'b0010011: return C_I;
      7'b0000011: return C_LW;
      7'b0100011: return C_SW;
      7'b1100011: return C_BR;
      7'b1101111: return C_JAL;
      7'b1100111: return C_JALR;
      default:    return C_ILL;
    endcase
  endfunction

  // {mask, value} of {a_sel, b_sel, imm_sel, alu_sel}; masked bits are unconstrained for that class
  function automatic logic [15:0] exp_sel(input int c, input logic [31:0] w);
    case (c)
      C_R:     return {8'hCF, 4'b0000, w[30], w[14:12]};
      C_I:     return {8'hFF, 4'b0100, 1'b0, w[14:12]};
      C_LW:    return {8'hFF, 8'b0100_0000};
      C_SW:    return {8'hFF, 8'b0101_0000};
      C_BR:    return {8'hFF, 8'b1110_0000};
      C_JAL:   return {8'hF0, 8'b1111_0000};
      default: return {8'hF0, 8'b0100_0000};
    endcase
  endfunction

  function automatic logic [31:0] rand_inst(input int c);
    logic [31:0] w;
    w = $urandom();
    case (c)
      C_R:     w[6:0] = 7'b0110011;
      C_I:     w[6:0] = 7'b0010011;
      C_LW:    w[6:0] = 7'b0000011;
      C_SW:    w[6:0] = 7'b0100011;
      C_BR:    begin w[6:0] = 7'b1100011; w[14:13] = 2'b00; end
      C_JAL:   w[6:0] = 7'b1101111;
      default: w[6:0] = 7'b1100111;
    endcase
    return w;
  endfunction

  // Entered at a falling edge; drives acks, checks just after, returns at the next falling edge.
  task automatic do_cycle(input logic ia, input logic da, input string tag, input logic [7:0] exp_s,
                          input logic [7:0] sel_mask, input logic [7:0] sel_exp,
                          input logic chk_wb, input logic [1:0] wb_exp);
    imem_ack_i = ia;
    dmem_ack_i = da;
    #1;
    check_val(tag, 64'(strobes), 64'(exp_s));
    if (sel_mask != 8'h00) check_val({tag, "_sel"}, 64'(sels & sel_mask), 64'(sel_exp));
    if (chk_wb) check_val({tag, "_wb"}, 64'(wb_sel_o), 64'(wb_exp));
    @(negedge clk);
  endtask

  task automatic do_reset();
    imem_ack_i = 1'b0;
    dmem_ack_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("rst_strobes", 64'(strobes), 64'(0));
    check_val("rst_sels", 64'({sels, wb_sel_o}), 64'(0));
    check_val("rst_instret", 64'(instret_o), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_val("idle_strobes", 64'(strobes), 64'(0));
    @(negedge clk);
    model_ret = '0;
  endtask

  task automatic trap_hold(input int n);
    for (int i = 0; i < n; i++)
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "trap", 8'h01, 8'h00, 8'h00, 1'b0, 2'b00);
  endtask

  // Starts at the first FETCH cycle. fd/md = ack-wait cycles; abort_at = MEM cycle to reset in (-1 none).
  task automatic run_instr(input logic [31:0] w, input logic breq, input int fd, input int md, input int abort_at);
    int          c;
    logic [2:0]  f3;
    logic        bad_br, taken, is_sw, ack, jmp;
    logic [15:0] es;
    c      = class_of(w);
    f3     = w[14:12];
    bad_br = (c == C_BR) && (f3 != 3'b000) && (f3 != 3'b001);
    taken  = (f3 == 3'b000) ? breq : !breq;
    is_sw  = (c == C_SW);
    jmp    = (c == C_JAL) || (c == C_JALR);
    es     = exp_sel(c, w);
    inst_i = w;
    breq_i = breq;

    for (int i = 0; i <= fd; i++) begin
      ack = (i == fd);
      do_cycle(ack, 1'($urandom_range(0, 1)), "fetch", {1'b1, ack, 6'b0}, 8'h00, 8'h00, 1'b0, 2'b00);
    end
    do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "decode", 8'h00, 8'h00, 8'h00, 1'b0, 2'b00);
    if (c == C_ILL) begin
      trap_hold(20);
      return;
    end

    if (bad_br) begin
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "exec_badbr", 8'h00, 8'h00, 8'h00, 1'b0, 2'b00);
      trap_hold(5);
      return;
    end
    do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "exec",
             (c == C_BR) ? {5'b0, 1'b1, taken, 1'b0} : 8'h00, es[15:8], es[7:0], 1'b0, 2'b00);
    if (c == C_BR) model_ret++;

    if ((c == C_LW) || is_sw) begin
      for (int i = 0; i <= md; i++) begin
        if (i == abort_at) begin
          do_reset();
          return;
        end
        ack = (i == md);
        do_cycle(1'($urandom_range(0, 1)), ack, "mem", {2'b00, 1'b1, is_sw, 1'b0, is_sw & ack, 2'b00},
                 es[15:8], es[7:0], 1'b0, 2'b00);
      end
      if (is_sw) model_ret++;
    end

    if ((c != C_BR) && !is_sw) begin
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "wb", {4'b0000, 1'b1, 1'b1, jmp, 1'b0},
               jmp ? es[15:8] : 8'h00, jmp ? es[7:0] : 8'h00, 1'b1,
               (c == C_LW) ? 2'b00 : (jmp ? 2'b10 : 2'b01));
      model_ret++;
    end
    check_val("instret", 64'(instret_o), 64'(model_ret));
  endtask

  initial begin
    int c, fd, md;
    @(negedge clk);
    rst_t_n = 1'b0;
    do_reset();

    run_instr(32'h00500093, 1'b0, 0, 0, -1);  // ADDI x1,x0,5
    run_instr(32'h00208463, 1'b1, 0, 0, -1);  // BEQ taken
    run_instr(32'h00208463, 1'b0, 1, 0, -1);  // BEQ not taken
    run_instr(32'h00209463, 1'b1, 0, 0, -1);  // BNE not taken
    run_instr(32'h00209463, 1'b0, 2, 0, -1);  // BNE taken
    run_instr(32'h0000A103, 1'b0, 0, 3, -1);  // LW, ack after 3 waits
    run_instr(32'h0020A023, 1'b0, 0, 1, -1);  // SW
    run_instr(32'h0000A103, 1'b0, 0, 6, 2);   // reset while LW waits in MEM
    run_instr(32'h00500093, 1'b0, 0, 0, -1);

    for (int k = 0; k < 80; k++) begin
      c  = int'($urandom_range(0, 6));
      fd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
      md = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
      run_instr(rand_inst(c), 1'($urandom_range(0, 1)), fd, md, -1);
    end

    run_instr(32'h0020A463, 1'b1, 0, 0, -1);  // branch with funct3 010
    do_reset();
    run_instr(32'h00000000, 1'b0, 1, 0, -1);  // illegal opcode
    do_reset();
    run_instr(32'h00500093, 1'b0, 0, 0, -1);

    rst_t_n = 1'b1;
    #1;
    check_val("tmo_idle", 64'(t_strobes), 64'(0));
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      check_val("tmo_wait", 64'(t_strobes), 64'(8'h80));
      @(negedge clk);
    end
    check_val("tmo_trap", 64'(t_strobes), 64'(8'h01));
    check_val("tmo_instret", 64'(t_instret), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32I-subset datapath: register file, ALU, immediate generator, A/B operand muxes, write-back mux, PC register, instruction and data memories.
- Walks each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB and drives the datapath selects and write strobes cycle by cycle.
- Holds on req/ack handshakes to instruction and data memory.
- Sits between the datapath and the memory interfaces; replaces purely combinational decode so that memories with variable latency can be used.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.
- ACK_TIMEOUT, 0, if nonzero: number of cycles a memory request may wait for ack before trapping; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- inst_i  in  32  instruction register contents, valid from DECODE onward.
- breq_i  in  1  branch comparator equal flag from datapath.
- imem_ack_i  in  1  instruction memory ack; read data valid this cycle.
- dmem_ack_i  in  1  data memory ack; read done or write accepted this cycle.
- imem_req_o  out  1  instruction fetch request at current PC.
- dmem_req_o  out  1  data memory request.
- dmem_we_o  out  1  data memory write enable, 1 = store; qualified by dmem_req_o.
- ir_we_o  out  1  instruction register load strobe.
- pc_we_o  out  1  PC load strobe.
- pc_sel_o  out  1  0 = PC+4, 1 = ALU result.
- rf_we_o  out  1  register file write strobe.
- alu_sel_o  out  4  {funct7[5] or 0, funct3}; 4'b0000 (add) for address/target computation.
- imm_sel_o  out  2  00 I, 01 S, 10 B, 11 J.
- a_sel_o  out  1  0 = rs1, 1 = PC.
- b_sel_o  out  1  0 = rs2, 1 = immediate.
- wb_sel_o  out  2  00 mem data, 01 ALU, 10 PC+4.
- trap_o  out  1  sticky illegal-opcode/timeout flag.
- instret_o  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, rst_n low): state = IDLE; all strobes and requests 0; selects 0; trap_o = 0; instret_o = 0. Outputs are decoded from the registered state, so nothing is asserted while in reset.
- IDLE -> FETCH unconditionally on the next edge after reset release.
- FETCH:
  - imem_req_o = 1 every cycle until imem_ack_i.
  - On the ack cycle: ir_we_o = 1 and next state is DECODE.
  - Ack in the same cycle as the first request is legal (one FETCH cycle).
- DECODE:
  - One cycle; opcode = inst_i[6:0].
  - Supported opcodes: 0110011 R, 0010011 I-ALU, 0000011 LW, 0100011 SW, 1100011 BEQ/BNE, 1101111 JAL, 1100111 JALR.
  - Any other opcode -> TRAP.
- EXEC:
  - Selects per class:
    - R: a=0, b=0, alu={inst[30],f3}.
    - I-ALU: a=0, b=1, imm=00, alu={0,f3}.
    - LW: a=0, b=1, imm=00, alu=0000.
    - SW: a=0, b=1, imm=01, alu=0000.
    - Branch: a=1, b=1, imm=10, alu=0000.
    - JAL: a=1, b=1, imm=11.
    - JALR: a=0, b=1, imm=00.
  - Next state: R/I-ALU/JAL/JALR -> WB; LW/SW -> MEM.
  - Branch: pc_we_o = 1 this cycle, then -> FETCH.
    - Taken = (f3==000 and breq_i) or (f3==001 and !breq_i).
    - pc_sel_o = taken.
    - Other f3 values -> TRAP.
- MEM:
  - dmem_req_o = 1 and dmem_we_o = (SW) until dmem_ack_i.
  - EXEC selects are held so the address stays stable.
  - On ack: LW -> WB; SW -> pc_we_o = 1, pc_sel_o = 0, -> FETCH.
- WB:
  - One cycle: rf_we_o = 1 and pc_we_o = 1.
  - wb_sel: 01 for R/I-ALU, 00 for LW, 10 for JAL/JALR.
  - pc_sel_o = 1 for JAL/JALR, else 0.
  - For JAL/JALR the ALU inputs are held from EXEC.
  - -> FETCH.
- Retirement: instret_o increments by 1 in every cycle with pc_we_o = 1 and wraps modulo 2^CNT_W.
- Latency (ack in first request cycle): branch 3 cycles; R/I/JAL/JALR/SW 4; LW 5. Each extra ack-wait cycle adds 1.
- TRAP: all strobes and requests 0; trap_o = 1. Exit is by reset only.
- Timeout (ACK_TIMEOUT > 0): a wait counter clears on state entry. If it reaches ACK_TIMEOUT with no ack in FETCH or MEM -> TRAP.
- Ack with no outstanding request is ignored.
- rf_we_o and dmem_we_o are never both 1; pc_we_o is at most 1 cycle per instruction.
- Reset mid-MEM or mid-FETCH: requests drop immediately (async). The memory side must tolerate an abandoned request.

Decomposition:
- Shared package (ctrl_pkg):
  - opcode constants;
  - state enum;
  - imm_sel, wb_sel and alu_sel encodings, shared with the datapath muxes.
- One natural sub-module, ctrl_decode: combinational opcode/funct3 to instruction class plus select values.
- multi_cycle_ctrl keeps the FSM, handshake wait, timeout counter and instret counter.

Test Plan:
- ADDI x1,x0,5 (0x00500093), imem ack immediate -> IDLE, FETCH, DECODE, EXEC, WB; in WB: rf_we=1, wb_sel=01, pc_we=1, pc_sel=0; instret_o=1.
- BEQ 0x00208463 with breq_i=1 -> pc_we=1, pc_sel=1 in EXEC; no rf_we; with breq_i=0 -> pc_sel=0; same encoding with f3=001 inverts pc_sel.
- LW 0x0000A103 with dmem_ack delayed 3 cycles -> dmem_req=1, dmem_we=0 for 4 MEM cycles; WB: rf_we=1, wb_sel=00; total 8 cycles.
- SW 0x0020A023 -> MEM: dmem_req=1, dmem_we=1; on ack: pc_we=1, rf_we never 1.
- Opcode 0x00000000 -> TRAP after DECODE; trap_o=1 and all strobes 0 for 20 cycles; rst_n low clears it and restarts at IDLE.
- rst_n pulled low mid-MEM with dmem_req=1 -> dmem_req=0 in the same cycle; instret_o=0; after release, FETCH is entered 1 cycle later.
